// File: rtl/csr_counter_ctrl.sv
// Machine performance-counter controller: owns cycle/instret and mcountinhibit, and
// arbitrates counter access between the WB-stage CSR port and a debug read port.
module csr_counter_ctrl #(
    parameter int DBG_MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IM_stall,
    input  logic        DM_stall,
    input  logic        retire,
    input  logic        csr_req,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        csr_busy,
    input  logic        dbg_valid,
    input  logic [11:0] dbg_addr,
    output logic        dbg_ready,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err
);

    localparam int WCW = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(DBG_MAX_WAIT);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CY_LO,
        SEL_CY_HI,
        SEL_IR_LO,
        SEL_IR_HI,
        SEL_INHIBIT
    } csr_sel_e;

    typedef struct packed {
        csr_sel_e sel;
        logic     ro;
    } csr_dec_t;

    function automatic csr_dec_t decode(input logic [11:0] addr);
        csr_dec_t d;
        d = '{sel: SEL_NONE, ro: 1'b0};
        case (addr)
            12'hC00: d = '{sel: SEL_CY_LO,   ro: 1'b1};
            12'hC80: d = '{sel: SEL_CY_HI,   ro: 1'b1};
            12'hC02: d = '{sel: SEL_IR_LO,   ro: 1'b1};
            12'hC82: d = '{sel: SEL_IR_HI,   ro: 1'b1};
            12'hB00: d = '{sel: SEL_CY_LO,   ro: 1'b0};
            12'hB80: d = '{sel: SEL_CY_HI,   ro: 1'b0};
            12'hB02: d = '{sel: SEL_IR_LO,   ro: 1'b0};
            12'hB82: d = '{sel: SEL_IR_HI,   ro: 1'b0};
            12'h320: d = '{sel: SEL_INHIBIT, ro: 1'b0};
            default: d = '{sel: SEL_NONE,    ro: 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic [31:0] read_sel(input csr_sel_e sel, input logic [63:0] cy,
                                             input logic [63:0] ir, input logic inh_cy,
                                             input logic inh_ir);
        case (sel)
            SEL_CY_LO:   return cy[31:0];
            SEL_CY_HI:   return cy[63:32];
            SEL_IR_LO:   return ir[31:0];
            SEL_IR_HI:   return ir[63:32];
            SEL_INHIBIT: return {29'b0, inh_ir, 1'b0, inh_cy};
            default:     return 32'h0;
        endcase
    endfunction

    logic [63:0]    cycle_q, instret_q, cycle_d, instret_d;
    logic           inh_cy, inh_ir;
    logic [WCW-1:0] wait_cnt;
    logic [31:0]    shadow;
    logic           shadow_is_ir;
    logic           shadow_vld;

    csr_dec_t    core_dec, dbg_dec;
    csr_op_e     op;
    logic [31:0] core_val, wr_val, dbg_val;
    logic        wr_en, instret_inc;

    assign core_dec = decode(csr_addr);
    assign dbg_dec  = decode(dbg_addr);
    assign op       = csr_op_e'(csr_op);

    assign dbg_ready = dbg_valid & (~csr_req | (wait_cnt == WAIT_MAX));
    assign csr_busy  = csr_req & dbg_ready;

    assign core_val    = read_sel(core_dec.sel, cycle_q, instret_q, inh_cy, inh_ir);
    assign csr_rdata   = csr_req ? core_val : 32'h0;
    assign csr_illegal = csr_req & ((core_dec.sel == SEL_NONE) |
                                    (core_dec.ro & (op != OP_READ)));

    assign wr_en = csr_req & ~csr_busy & ~IM_stall & ~DM_stall & ~csr_illegal & (op != OP_READ);
    assign instret_inc = retire & ~IM_stall & ~DM_stall & ~inh_ir;

    // NOTE: every variable gets a default at the top of the block so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    always_comb begin
        wr_val = csr_wdata;
        case (op)
            OP_SET:   wr_val = core_val | csr_wdata;
            OP_CLEAR: wr_val = core_val & ~csr_wdata;
            default:  wr_val = csr_wdata;
        endcase
    end

    // Writing one half overrides the increment for that half; the carry across halves
    // in that cycle is lost in both directions.
    always_comb begin
        cycle_d   = cycle_q + {63'b0, ~inh_cy};
        instret_d = instret_q + {63'b0, instret_inc};
        if (wr_en) begin
            case (core_dec.sel)
                SEL_CY_LO: cycle_d   = {cycle_q[63:32], wr_val};
                SEL_CY_HI: cycle_d   = {wr_val, cycle_d[31:0]};
                SEL_IR_LO: instret_d = {instret_q[63:32], wr_val};
                SEL_IR_HI: instret_d = {wr_val, instret_d[31:0]};
                default: ;
            endcase
        end
    end

    // A high-half debug read following a low-half read of the same counter returns the
    // high half captured alongside the low half, so the 64-bit pair is coherent.
    always_comb begin
        dbg_val = read_sel(dbg_dec.sel, cycle_q, instret_q, inh_cy, inh_ir);
        if (shadow_vld && (((dbg_dec.sel == SEL_CY_HI) && !shadow_is_ir) ||
                           ((dbg_dec.sel == SEL_IR_HI) &&  shadow_is_ir)))
            dbg_val = shadow;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q      <= '0;
            instret_q    <= '0;
            inh_cy       <= 1'b0;
            inh_ir       <= 1'b0;
            wait_cnt     <= '0;
            shadow       <= '0;
            shadow_is_ir <= 1'b0;
            shadow_vld   <= 1'b0;
            dbg_rvalid   <= 1'b0;
            dbg_rdata    <= '0;
            dbg_err      <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;

            if (wr_en && core_dec.sel == SEL_INHIBIT) begin
                inh_cy <= wr_val[0];
                inh_ir <= wr_val[2];
            end

            if (!dbg_valid || dbg_ready)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WCW'(1);

            dbg_rvalid <= dbg_ready;
            dbg_rdata  <= dbg_ready ? dbg_val : 32'h0;
            dbg_err    <= dbg_ready & (dbg_dec.sel == SEL_NONE);

            if (wr_en && (shadow_is_ir ? (core_dec.sel inside {SEL_IR_LO, SEL_IR_HI})
                                       : (core_dec.sel inside {SEL_CY_LO, SEL_CY_HI})))
                shadow_vld <= 1'b0;

            if (dbg_ready) begin
                case (dbg_dec.sel)
                    SEL_CY_LO: begin
                        shadow       <= cycle_q[63:32];
                        shadow_is_ir <= 1'b0;
                        shadow_vld   <= 1'b1;
                    end
                    SEL_IR_LO: begin
                        shadow       <= instret_q[63:32];
                        shadow_is_ir <= 1'b1;
                        shadow_vld   <= 1'b1;
                    end
                    default: shadow_vld <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_counter_ctrl.sv
// Directed bench for csr_counter_ctrl: counting, write/increment overlap, inhibit,
// debug snapshot, bounded-wait arbitration, illegal accesses and reset.
module tb_csr_counter_ctrl;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        IM_stall, DM_stall, retire;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal, csr_busy;
    logic        dbg_valid;
    logic [11:0] dbg_addr;
    logic        dbg_ready, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int failures = 0;

    // Expected cycle counter; overridden by hand after each write to it.
    logic [63:0] exp_cy;
    bit          cy_run;
    logic [31:0] exp_lo;

    csr_counter_ctrl #(.DBG_MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst), .IM_stall(IM_stall), .DM_stall(DM_stall), .retire(retire),
        .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .csr_busy(csr_busy),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cy_run) exp_cy++;
    endtask

    task automatic peek(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        csr_req  = 1'b1;
        csr_op   = OP_READ;
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
        csr_req = 1'b0;
    endtask

    task automatic core(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_req   = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        tick();
        csr_req = 1'b0;
    endtask

    task automatic dbg_read(input logic [11:0] addr);
        dbg_valid = 1'b1;
        dbg_addr  = addr;
        tick();
        dbg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; IM_stall = 1'b0; DM_stall = 1'b0; retire = 1'b0;
        csr_req = 1'b0; csr_op = OP_READ; csr_addr = '0; csr_wdata = '0;
        dbg_valid = 1'b0; dbg_addr = '0;
        cy_run = 1'b0; exp_cy = '0;

        repeat (2) tick();
        check("rst_rvalid", dbg_rvalid, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_err", dbg_err, 0);
        peek(12'hC00, 32'h0, "rst_cycle");
        peek(12'hC02, 32'h0, "rst_instret");
        peek(12'h320, 32'h0, "rst_inhibit");
        #1;
        check("noreq_rdata", csr_rdata, 0);
        check("noreq_illegal", csr_illegal, 0);

        rst = 1'b0; cy_run = 1'b1;
        repeat (10) tick();
        peek(12'hC00, 32'd10, "cycle_after_10");
        peek(12'hC02, 32'd0, "instret_idle");

        core(OP_WRITE, 12'hB00, 32'hFFFF_FFFF); exp_cy = 64'h0000_0000_FFFF_FFFF;
        peek(12'hC00, 32'hFFFF_FFFF, "wr_lo_val");
        peek(12'hC80, 32'h0, "wr_lo_hi_hold");
        tick();
        peek(12'hC00, 32'h0, "carry_lo");
        peek(12'hC80, 32'h1, "carry_hi");
        core(OP_WRITE, 12'hB80, 32'd5); exp_cy = 64'h0000_0005_0000_0001;
        peek(12'hB00, 32'h1, "wr_hi_lo_inc");
        peek(12'hB80, 32'h5, "wr_hi_val");
        core(OP_WRITE, 12'hB00, 32'hFFFF_FFFF); exp_cy = 64'h0000_0005_FFFF_FFFF;
        core(OP_WRITE, 12'hB80, 32'd7); exp_cy = 64'h0000_0007_0000_0000;
        peek(12'hB00, 32'h0, "wr_hi_lo_wrap");
        peek(12'hB80, 32'h7, "wr_hi_carry_dropped");

        retire = 1'b1; DM_stall = 1'b1;
        repeat (3) tick();
        peek(12'hC02, 32'd0, "instret_dm_stall");
        DM_stall = 1'b0;
        repeat (2) tick();
        peek(12'hC02, 32'd2, "instret_retire2");
        IM_stall = 1'b1;
        tick();
        IM_stall = 1'b0;
        peek(12'hC02, 32'd2, "instret_im_stall");
        core(OP_SET, 12'h320, 32'h4);
        peek(12'h320, 32'h4, "inhibit_ir_set");
        repeat (3) tick();
        peek(12'hC02, 32'd3, "instret_frozen");
        peek(12'hC00, 32'hA, "cycle_runs_ir_inh");
        peek(12'hC80, 32'h7, "cycle_hi_stable");
        retire = 1'b0;
        core(OP_CLEAR, 12'h320, 32'h4);
        peek(12'h320, 32'h0, "inhibit_clear");

        core(OP_WRITE, 12'h320, 32'hFFFF_FFFF); cy_run = 1'b0;
        peek(12'h320, 32'h5, "inhibit_mask");
        repeat (2) tick();
        peek(12'hC00, 32'hC, "cycle_frozen");
        core(OP_WRITE, 12'h320, 32'h0); cy_run = 1'b1;
        tick();
        peek(12'hC00, 32'hD, "cycle_resume");

        IM_stall = 1'b1;
        core(OP_WRITE, 12'hB02, 32'hAB);
        IM_stall = 1'b0;
        peek(12'hC02, 32'd3, "stalled_write_dropped");

        core(OP_WRITE, 12'hB02, 32'hFFFF_FFFF);
        dbg_read(12'hC02);
        check("snap_lo_rvalid", dbg_rvalid, 1);
        check("snap_lo_rdata", dbg_rdata, 32'hFFFF_FFFF);
        check("snap_lo_err", dbg_err, 0);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        check("rvalid_pulse", dbg_rvalid, 0);
        peek(12'hC82, 32'h1, "instret_wrapped_hi");
        dbg_read(12'hC82);
        check("snap_hi_rvalid", dbg_rvalid, 1);
        check("snap_hi_rdata", dbg_rdata, 32'h0);
        dbg_read(12'hC82);
        check("snap_hi_live", dbg_rdata, 32'h1);
        dbg_read(12'hC02);
        check("snap2_lo_rdata", dbg_rdata, 32'h0);
        core(OP_WRITE, 12'hB82, 32'h55);
        dbg_read(12'hC82);
        check("snap_cleared_by_write", dbg_rdata, 32'h55);

        csr_req = 1'b1; csr_op = OP_READ; csr_addr = 12'hC00;
        dbg_valid = 1'b1; dbg_addr = 12'hC00;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("arb_wait%0d_ready", i), dbg_ready, 0);
            check($sformatf("arb_wait%0d_busy", i), csr_busy, 0);
            tick();
        end
        #1;
        check("arb_grant_ready", dbg_ready, 1);
        check("arb_grant_busy", csr_busy, 1);
        exp_lo = exp_cy[31:0];
        tick();
        #1;
        check("arb_after_ready", dbg_ready, 0);
        check("arb_after_busy", csr_busy, 0);
        check("arb_rvalid", dbg_rvalid, 1);
        check("arb_rdata", dbg_rdata, exp_lo);
        csr_req = 1'b0; dbg_valid = 1'b0;

        csr_req = 1'b1; csr_op = OP_WRITE; csr_addr = 12'hC00; csr_wdata = 32'h1234;
        #1;
        check("ill_ro_write", csr_illegal, 1);
        tick();
        csr_req = 1'b0;
        peek(12'hC00, exp_cy[31:0], "ill_no_change");
        csr_req = 1'b1; csr_op = OP_READ; csr_addr = 12'h123;
        #1;
        check("ill_unknown", csr_illegal, 1);
        check("ill_unknown_rdata", csr_rdata, 0);
        csr_op = OP_SET; csr_addr = 12'hC80;
        #1;
        check("ill_ro_set", csr_illegal, 1);
        csr_op = OP_READ;
        #1;
        check("legal_ro_read", csr_illegal, 0);
        csr_req = 1'b0;
        dbg_read(12'h123);
        check("dbg_bad_rvalid", dbg_rvalid, 1);
        check("dbg_bad_err", dbg_err, 1);
        check("dbg_bad_rdata", dbg_rdata, 0);

        dbg_valid = 1'b1; dbg_addr = 12'hC00;
        rst = 1'b1; cy_run = 1'b0;
        tick();
        dbg_valid = 1'b0;
        check("rst_drop_rvalid", dbg_rvalid, 0);
        check("rst_drop_rdata", dbg_rdata, 0);
        peek(12'hC00, 32'h0, "rst_mid_cycle");
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
